hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline hazard detection unit. It replaces fixed EX/M stage comparisons with a per-register scoreboard of down-counters, so producers of any latency from 0 to MAX_LATENCY are handled uniformly. It sits in ID. It issues `stall` to the PC/IF-ID registers and a bubble to ID/EX, and it honours global pipeline freeze and ID flush.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_reg_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 70 +++++++
 tb/tb_hazard_scoreboard.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and counter-width helper for the hazard scoreboard
package hazard_pkg;
  localparam int DEF_MAX_LATENCY = 4;
  localparam int MARGIN_BRANCH = 0;
  localparam int MARGIN_NORMAL = 1;
  localparam int MARGIN_STORE = 2;
  function automatic int cnt_width(input int max_latency);
    return $clog2(max_latency + 2);
  endfunction
endpackage

// File: rtl/hazard_reg_counter.sv
// hazard_reg_counter: per-register down-counter with load, freeze and sync reset
// ports: clk, reset, freeze_i (hold), load_i/load_val_i (new count), count_o, busy_o (registered count != 0)
module hazard_reg_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         freeze_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         busy_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic busy_q;
  always_comb cnt_d = freeze_i ? cnt_q : load_i ? load_val_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy_q <= cnt_d != '0;
    end
  end
  assign count_o = cnt_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage scoreboard of per-register down-counters producing stall/bubble
// ports: clk, reset, ID operand/destination info (opcode, valid_id, branch, mem_write_id, use_*_id,
//   reg_*_id, reg_write_id, write_reg_id, latency_id), freeze, flush_id; outputs stall (comb), busy_mask (reg),
//   stall_cycles when HAZARD_PERF_EN is defined
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int LEN_OP_CODE = 6,
  parameter logic [LEN_OP_CODE-1:0] OP_J = 'h02,
  parameter int MAX_LATENCY = DEF_MAX_LATENCY,
  parameter int LEN_CNT = cnt_width(MAX_LATENCY),
  parameter int NUM_REGS = 2 ** LEN_REG_FILE_ADDR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEN_OP_CODE-1:0]       opcode,
  input  logic                         valid_id,
  input  logic                         branch,
  input  logic                         mem_write_id,
  input  logic                         use_1_id,
  input  logic                         use_2_id,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_1_id,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_2_id,
  input  logic                         reg_write_id,
  input  logic [LEN_REG_FILE_ADDR-1:0] write_reg_id,
  input  logic [LEN_CNT-1:0]           latency_id,
  input  logic                         freeze,
  input  logic                         flush_id,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                  stall_cycles,
`endif
  output logic                         stall,
  output logic [NUM_REGS-1:0]          busy_mask
);
  localparam logic [LEN_CNT-1:0] MAX_L = LEN_CNT'(MAX_LATENCY);
  logic [NUM_REGS-1:0][LEN_CNT-1:0] cnt;
  logic [LEN_CNT-1:0] margin_1, margin_2, lat_c;
  logic haz_1, haz_2, issue;
  // store data is forwarded in MEM, so it tolerates one more cycle of outstanding latency
  assign margin_1 = branch ? LEN_CNT'(MARGIN_BRANCH) : LEN_CNT'(MARGIN_NORMAL);
  assign margin_2 = branch ? LEN_CNT'(MARGIN_BRANCH) : mem_write_id ? LEN_CNT'(MARGIN_STORE) : LEN_CNT'(MARGIN_NORMAL);
  assign haz_1 = use_1_id && reg_1_id != '0 && cnt[reg_1_id] > margin_1;
  assign haz_2 = use_2_id && reg_2_id != '0 && cnt[reg_2_id] > margin_2;
  assign stall = valid_id && !reset && opcode != OP_J && (haz_1 || haz_2);
  assign issue = valid_id && !stall && !freeze && !flush_id;
  assign lat_c = latency_id > MAX_L ? MAX_L : latency_id;
  assign cnt[0] = '0;
  assign busy_mask[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    hazard_reg_counter #(.W(LEN_CNT)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .freeze_i   (freeze),
      .load_i     (issue && reg_write_id && write_reg_id == LEN_REG_FILE_ADDR'(r)),
      .load_val_i (lat_c + LEN_CNT'(1)),
      .count_o    (cnt[r]),
      .busy_o     (busy_mask[r])
    );
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb perf_d = (stall && !freeze) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign stall_cycles = perf_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random check of hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, valid_id, branch, mem_write_id, use_1_id, use_2_id, reg_write_id, freeze, flush_id, stall;
  logic [5:0] opcode;
  logic [4:0] reg_1_id, reg_2_id, write_reg_id;
  logic [2:0] latency_id;
  logic [31:0] busy_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif
  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .opcode(opcode), .valid_id(valid_id), .branch(branch),
    .mem_write_id(mem_write_id), .use_1_id(use_1_id), .use_2_id(use_2_id),
    .reg_1_id(reg_1_id), .reg_2_id(reg_2_id), .reg_write_id(reg_write_id),
    .write_reg_id(write_reg_id), .latency_id(latency_id), .freeze(freeze), .flush_id(flush_id),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .stall(stall), .busy_mask(busy_mask)
  );
  int checks = 0, fails = 0;
  longint avail [32];
  longint now = 0;
  int unsigned perf = 0;
  logic last_stall;
  int bwatch = 0, bcnt = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint rem(input int a);
    return avail[a] > now ? avail[a] - now : 0;
  endfunction
  task automatic cyc();
    bit es;
    logic [31:0] eb;
    int m1, m2;
    #1;
    m1 = branch ? 0 : 1;
    m2 = branch ? 0 : (mem_write_id ? 2 : 1);
    es = valid_id && !reset && opcode != 6'h02 &&
         ((use_1_id && reg_1_id != 0 && rem(int'(reg_1_id)) > m1) ||
          (use_2_id && reg_2_id != 0 && rem(int'(reg_2_id)) > m2));
    eb = '0;
    for (int r = 1; r < 32; r++) eb[r] = rem(r) != 0;
    chk("stall", {31'b0, stall}, {31'b0, es});
    chk("busy_mask", busy_mask, eb);
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, perf);
`endif
    last_stall = stall;
    if (busy_mask[bwatch]) bcnt++;
    if (reset) begin
      for (int r = 0; r < 32; r++) avail[r] = 0;
      perf = 0;
    end else if (!freeze) begin
      if (es) perf++;
      if (valid_id && !es && !flush_id && reg_write_id && write_reg_id != 0)
        avail[write_reg_id] = now + (latency_id > 4 ? 4 : latency_id) + 2;
      now++;
    end
    @(negedge clk);
    #1;
  endtask
  task automatic clr();
    reset = 0; opcode = 6'h00; valid_id = 0; branch = 0; mem_write_id = 0; use_1_id = 0; use_2_id = 0;
    reg_1_id = 0; reg_2_id = 0; reg_write_id = 0; write_reg_id = 0; latency_id = 0; freeze = 0; flush_id = 0;
  endtask
  task automatic dep(input string tag, input int wr, input int lat, input bit br, input bit mw, input bit src2,
                     input logic [5:0] op, input int frz, input bit flush_p, input int exp_n, output int b);
    int n, k;
    n = 0; k = 0;
    clr();
    repeat (6) cyc();
    valid_id = 1; reg_write_id = 1; write_reg_id = 5'(wr); latency_id = 3'(lat); flush_id = flush_p;
    cyc();
    bwatch = wr; bcnt = 0;
    clr();
    valid_id = 1; opcode = op; branch = br; mem_write_id = mw;
    if (src2) begin use_2_id = 1; reg_2_id = 5'(wr); end
    else begin use_1_id = 1; reg_1_id = 5'(wr); end
    do begin
      freeze = k < frz;
      cyc();
      if (last_stall) n++;
      k++;
    end while (last_stall && k < 30);
    clr();
    repeat (6) cyc();
    chk(tag, n, exp_n);
    b = bcnt;
  endtask
  initial begin
    int b;
    clr();
    reset = 1;
    for (int r = 0; r < 32; r++) avail[r] = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    valid_id = 1; use_1_id = 1; reg_1_id = 5;
    cyc();
    chk("reset_stall0", {31'b0, last_stall}, 32'd0);
    chk("reset_busy0", busy_mask, 32'd0);
    dep("load_use", 5, 1, 0, 0, 0, 6'h00, 0, 0, 1, b);
    chk("load_use_busy", b, 2);
    dep("alu_branch", 7, 0, 1, 0, 0, 6'h04, 0, 0, 1, b);
    dep("load_branch", 7, 1, 1, 0, 0, 6'h04, 0, 0, 2, b);
    dep("store_data", 3, 1, 0, 1, 1, 6'h2b, 0, 0, 0, b);
    dep("store_base", 3, 1, 0, 1, 0, 6'h2b, 0, 0, 1, b);
    dep("lat4_plain", 9, 4, 0, 0, 0, 6'h00, 0, 0, 4, b);
    dep("lat4_freeze3", 9, 4, 0, 0, 0, 6'h00, 3, 0, 7, b);
    dep("lat4_jump", 9, 4, 0, 0, 0, 6'h02, 0, 0, 0, b);
    dep("lat_clamp", 9, 7, 0, 0, 0, 6'h00, 0, 0, 4, b);
    dep("write_r0", 0, 4, 1, 0, 0, 6'h04, 0, 0, 0, b);
    dep("flushed", 5, 4, 1, 0, 0, 6'h04, 0, 1, 0, b);
    chk("flushed_busy", b, 0);
    clr();
    repeat (6) cyc();
    valid_id = 1; reg_write_id = 1; write_reg_id = 9; latency_id = 4;
    cyc();
    clr();
    valid_id = 1; use_1_id = 1; reg_1_id = 9;
    cyc();
    cyc();
    reset = 1;
    cyc();
    chk("reset_mid_stall", {31'b0, last_stall}, 32'd0);
    reset = 0;
    cyc();
    chk("reset_busy_after", busy_mask, 32'd0);
    chk("reset_no_stall", {31'b0, last_stall}, 32'd0);
`ifdef HAZARD_PERF_EN
    reset = 1;
    cyc();
    dep("perf_lu1", 5, 1, 0, 0, 0, 6'h00, 0, 0, 1, b);
    dep("perf_lu2", 5, 1, 0, 0, 0, 6'h00, 0, 0, 1, b);
    chk("perf_two", stall_cycles, 32'd2);
`endif
    bwatch = 0;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom % 50) == 0;
      valid_id = ($urandom % 4) != 0;
      opcode = ($urandom % 8) == 0 ? 6'h02 : 6'($urandom);
      branch = ($urandom % 5) == 0;
      mem_write_id = ($urandom % 4) == 0;
      use_1_id = 1'($urandom);
      use_2_id = 1'($urandom);
      reg_1_id = 5'($urandom % 8);
      reg_2_id = 5'($urandom % 8);
      reg_write_id = 1'($urandom);
      write_reg_id = 5'($urandom % 8);
      latency_id = 3'($urandom);
      freeze = ($urandom % 8) == 0;
      flush_id = ($urandom % 10) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
